uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; SHALL be even and >= 4.
REQ-002 Port clk  input  1  system clock, all logic on rising edge.
REQ-003 Port reset  input  1  reset, asynchronous, active-high.
REQ-004 Port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 Port data_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-006 Port data_out  output  8  received byte.
REQ-007 Port data_valid  output  1  data_out holds an unconsumed byte.
REQ-008 Port busy  output  1  high whenever state is not IDLE.
REQ-009 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port overrun  output  1  one-cycle pulse: byte completed while data_valid still high.
REQ-011 Port parity_err  output  1  one-cycle pulse: parity mismatch; see Configuration.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value rx_s.
REQ-013 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 IDLE: on rx_s high-to-low transition, go to START and clear the bit-timer.
REQ-015 START: after CLKS_PER_BIT/2 cycles, sample rx_s; low -> DATA with timer cleared; high -> false start, back to IDLE, no flags raised.
REQ-016 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit), 8 samples, first sample = bit 7 (MSB-first frame), last = bit 0.
REQ-017 After the 8th data sample, go to PARITY if compiled in, else STOP.
REQ-018 STOP: sample rx_s after CLKS_PER_BIT cycles; high -> frame accepted; low -> frame_err pulse, byte discarded; either case return to IDLE next cycle.
REQ-019 Accepted byte SHALL appear on data_out with data_valid high on the cycle after the stop sample.
REQ-020 data_valid SHALL stay high, data_out stable, until a cycle with data_valid and data_ready both high; data_valid clears the following cycle.
REQ-021 Byte accepted while data_valid high and data_ready low: overrun pulse, new byte dropped, old byte kept.
REQ-022 Byte accepted in the same cycle as a handshake: new byte loaded, data_valid stays high, no overrun.
REQ-023 A new start edge SHALL be detected no earlier than the cycle after return to IDLE; back-to-back frames with a 1-bit stop SHALL be received without loss.
REQ-024 frame_err, overrun, parity_err SHALL never be asserted in the same cycle as one another.

Reset
REQ-025 Asynchronous reset SHALL force state IDLE, timers and bit counter 0, synchronizer flops 1.
REQ-026 During reset, data_out = 8'h00, data_valid = busy = frame_err = overrun = parity_err = 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release, reception resumes only on a fresh falling edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit CLKS_PER_BIT after the last data sample; mismatch -> parity_err pulse, byte discarded, STOP skipped, return to IDLE.
REQ-029 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is start + 8 data + stop, parity_err tied 0.

Verification
REQ-030 Frame 8'hA5, CLKS_PER_BIT=16, data_ready=1 -> data_out=8'hA5, data_valid one cycle, no error flags.
REQ-031 Glitch: rx low 4 cycles then high -> busy for 8 cycles, returns IDLE, no data_valid, no flags.
REQ-032 Frame 8'h3C with stop bit 0 -> frame_err one pulse, data_valid stays 0.
REQ-033 data_ready=0, frames 8'h11 then 8'h22 -> data_out=8'h11 held, overrun pulse on second frame; then data_ready=1 -> handshake, data_valid clears.
REQ-034 Reset asserted after 4th data bit of 8'hFF, released, then frame 8'h5A -> only 8'h5A delivered.
REQ-035 With UART_RX_PARITY_EN, frame 8'h07 with parity bit 0 -> parity_err pulse, no data_valid; with parity bit 1 -> 8'h07 delivered.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: MSB-first 8N1 serial receiver with ready/valid output; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic rx_m, rx_s, rx_p;
  logic [TW-1:0] timer;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic half_tick, bit_tick, fall, accept, hold, clr;
  assign half_tick = timer == TW'(CLKS_PER_BIT / 2 - 1);
  assign bit_tick  = timer == TW'(CLKS_PER_BIT - 1);
  assign fall      = rx_p & ~rx_s;
  assign accept    = state == STOP && bit_tick && rx_s;
  assign hold      = data_valid & ~data_ready;
  assign busy      = state != IDLE;
  assign clr       = state == IDLE || state_n != state || bit_tick;
  // two-flop synchronizer plus previous sample for falling-edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) {rx_m, rx_s, rx_p} <= 3'b111;
    else {rx_m, rx_s, rx_p} <= {rx, rx_m, rx_s};
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next-state: start sampled mid-bit, data/parity/stop one bit period apart
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = fall ? START : IDLE;
      START:  state_n = half_tick ? (rx_s ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA:   state_n = (bit_tick && bit_cnt == 3'd7) ? PARITY : DATA;
      PARITY: state_n = bit_tick ? ((rx_s == ^shift) ? STOP : IDLE) : PARITY;
`else
      DATA:   state_n = (bit_tick && bit_cnt == 3'd7) ? STOP : DATA;
`endif
      STOP:   state_n = bit_tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // bit timer, bit counter and shift register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      timer   <= clr ? '0 : timer + 1'b1;
      bit_cnt <= state == IDLE ? 3'd0 : (state == DATA && bit_tick) ? bit_cnt + 3'd1 : bit_cnt;
      shift   <= (state == DATA && bit_tick) ? {shift[6:0], rx_s} : shift;
    end
  // output byte handshake and one-cycle error pulses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= state == STOP && bit_tick && !rx_s;
      overrun    <= accept && hold;
      data_out   <= (accept && !hold) ? shift : data_out;
      data_valid <= (accept && !hold) ? 1'b1 : (data_valid && data_ready) ? 1'b0 : data_valid;
    end
`ifdef UART_RX_PARITY_EN
  // even-parity mismatch pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) parity_err <= 1'b0;
    else parity_err <= state == PARITY && bit_tick && rx_s != ^shift;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, data_ready = 1'b0;
  logic [7:0] data_out;
  logic data_valid, busy, frame_err, overrun, parity_err;
  int compared = 0, mismatched = 0;
  int valid_cyc = 0, busy_cyc = 0, fe_cyc = 0, ov_cyc = 0, pe_cyc = 0, multi_cyc = 0, hs_cnt = 0;
  logic [7:0] got_byte = 8'h00, prev_byte = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_ready(data_ready),
    .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // observe outputs on the falling edge
  always @(negedge clk)
    if (!reset) begin
      valid_cyc += int'(data_valid);
      busy_cyc  += int'(busy);
      fe_cyc    += int'(frame_err);
      ov_cyc    += int'(overrun);
      pe_cyc    += int'(parity_err);
      if (int'(frame_err) + int'(overrun) + int'(parity_err) > 1) multi_cyc++;
      if (data_valid && data_ready) begin
        prev_byte = got_byte;
        got_byte  = data_out;
        hs_cnt++;
      end
    end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    tick(3);
    compared++;
    if ({data_out, data_valid, busy, frame_err, overrun, parity_err} !== 13'h0) begin
      $display("FAIL reset_outputs: got %h required 0", {data_out, data_valid, busy, frame_err, overrun, parity_err});
      mismatched++;
    end
    reset = 1'b0;
    tick(5);
    compared++;
    if ({busy, data_valid} !== 2'b00) begin
      $display("FAIL reset_idle: busy/valid got %b required 00", {busy, data_valid});
      mismatched++;
    end
  endtask

  task automatic test_basic;
    int h0 = hs_cnt, v0 = valid_cyc, f0 = fe_cyc + ov_cyc + pe_cyc;
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    tick(CPB);
    compared++;
    if (hs_cnt - h0 !== 1 || got_byte !== 8'hA5) begin
      $display("FAIL basic_byte: got %0d bytes last %h required 1 byte a5", hs_cnt - h0, got_byte);
      mismatched++;
    end
    compared++;
    if (valid_cyc - v0 !== 1) begin
      $display("FAIL basic_valid_len: got %0d cycles required 1", valid_cyc - v0);
      mismatched++;
    end
    compared++;
    if (fe_cyc + ov_cyc + pe_cyc - f0 !== 0) begin
      $display("FAIL basic_flags: got %0d flag cycles required 0", fe_cyc + ov_cyc + pe_cyc - f0);
      mismatched++;
    end
  endtask

  task automatic test_glitch;
    int b0 = busy_cyc, v0 = valid_cyc, f0 = fe_cyc + ov_cyc + pe_cyc;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    compared++;
    if (busy_cyc - b0 !== 8) begin
      $display("FAIL glitch_busy: got %0d cycles required 8", busy_cyc - b0);
      mismatched++;
    end
    compared++;
    if (valid_cyc - v0 !== 0 || fe_cyc + ov_cyc + pe_cyc - f0 !== 0 || busy !== 1'b0) begin
      $display("FAIL glitch_quiet: got valid %0d flags %0d busy %b required 0 0 0",
               valid_cyc - v0, fe_cyc + ov_cyc + pe_cyc - f0, busy);
      mismatched++;
    end
  endtask

  task automatic test_frame_err;
    int v0 = valid_cyc, e0 = fe_cyc;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    tick(CPB);
    compared++;
    if (fe_cyc - e0 !== 1) begin
      $display("FAIL frame_err_pulse: got %0d cycles required 1", fe_cyc - e0);
      mismatched++;
    end
    compared++;
    if (valid_cyc - v0 !== 0) begin
      $display("FAIL frame_err_valid: got %0d valid cycles required 0", valid_cyc - v0);
      mismatched++;
    end
  endtask

  task automatic test_overrun;
    int o0 = ov_cyc, h0 = hs_cnt;
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    tick(CPB);
    compared++;
    if (data_out !== 8'h11 || data_valid !== 1'b1) begin
      $display("FAIL overrun_hold: got %h valid %b required 11 valid 1", data_out, data_valid);
      mismatched++;
    end
    compared++;
    if (ov_cyc - o0 !== 1) begin
      $display("FAIL overrun_pulse: got %0d cycles required 1", ov_cyc - o0);
      mismatched++;
    end
    data_ready = 1'b1;
    tick(2);
    compared++;
    if (data_valid !== 1'b0 || hs_cnt - h0 !== 1 || got_byte !== 8'h11) begin
      $display("FAIL overrun_drain: got valid %b bytes %0d last %h required 0 1 11", data_valid, hs_cnt - h0, got_byte);
      mismatched++;
    end
  endtask

  task automatic test_back_to_back;
    int h0 = hs_cnt;
    data_ready = 1'b1;
    send_frame(8'h81, 1'b1, ^8'h81);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    tick(CPB);
    compared++;
    if (hs_cnt - h0 !== 2 || prev_byte !== 8'h81 || got_byte !== 8'h7E) begin
      $display("FAIL back_to_back: got %0d bytes %h %h required 2 bytes 81 7e", hs_cnt - h0, prev_byte, got_byte);
      mismatched++;
    end
  endtask

  task automatic test_reset_mid;
    int h0, e0;
    data_ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    #1;
    compared++;
    if ({busy, data_valid, data_out} !== 10'h0) begin
      $display("FAIL reset_mid_async: got %h required 0", {busy, data_valid, data_out});
      mismatched++;
    end
    tick(3);
    reset = 1'b0;
    tick(2 * CPB);
    h0 = hs_cnt;
    e0 = fe_cyc + ov_cyc + pe_cyc;
    send_frame(8'h5A, 1'b1, ^8'h5A);
    tick(CPB);
    compared++;
    if (hs_cnt - h0 !== 1 || got_byte !== 8'h5A || fe_cyc + ov_cyc + pe_cyc - e0 !== 0) begin
      $display("FAIL reset_mid_resume: got %0d bytes last %h flags %0d required 1 5a 0",
               hs_cnt - h0, got_byte, fe_cyc + ov_cyc + pe_cyc - e0);
      mismatched++;
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int p0 = pe_cyc, v0 = valid_cyc, h0;
    data_ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(CPB);
    compared++;
    if (pe_cyc - p0 !== 1 || valid_cyc - v0 !== 0) begin
      $display("FAIL parity_bad: got pulses %0d valid %0d required 1 0", pe_cyc - p0, valid_cyc - v0);
      mismatched++;
    end
    h0 = hs_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(CPB);
    compared++;
    if (hs_cnt - h0 !== 1 || got_byte !== 8'h07) begin
      $display("FAIL parity_good: got %0d bytes last %h required 1 07", hs_cnt - h0, got_byte);
      mismatched++;
    end
  endtask
`endif

  task automatic test_exclusive;
    compared++;
    if (multi_cyc !== 0) begin
      $display("FAIL flags_exclusive: got %0d overlapping cycles required 0", multi_cyc);
      mismatched++;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
